seg_p2s_shifter: RTL
====================

# seg_p2s_shifter

Parallel-to-serial driver for the 8-digit 7-segment display chain. Consumes the 64-bit segment pattern produced by the hex-to-segment encoder stage. Shifts it MSB-first into the board's external 74HC164/595-style shift-register chain, then pulses the latch/enable line. Sits between the segment encoder and the display pins; one transfer per `start` request, or self-refreshing when so configured.

## Interface
Parameters:
- `DATA_BITS`, 64: pattern width; ≥ 2.
- `CLK_DIV`, 2: half-period of `s_clk` in `clk` cycles; ≥ 1.
- `REFRESH_CYCLES`, 1024: idle gap before an automatic transfer; used only with `P2S_AUTOREFRESH_EN`.

Ports:
- `clk`  in  1  system clock, all logic on rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `start`  in  1  transfer request, sampled each `clk`.
- `P_Data`  in  DATA_BITS  segment pattern, captured only on accepted start.
- `s_clk`  out  1  serial shift clock to display chain.
- `s_clrn`  out  1  chain clear, active-low.
- `sout`  out  1  serial data.
- `EN`  out  1  latch/output-enable pulse to chain.
- `busy`  out  1  transfer in progress.
- `done`  out  1  one-cycle completion strobe.

## Operation
- States: IDLE, SHIFT, LATCH.
- Reset (`rstn`=0, asynchronous): state IDLE; `s_clk`=0, `s_clrn`=0, `sout`=0, `EN`=0, `busy`=0, `done`=0; shift register, bit counter and phase counter cleared.
- After reset release, `s_clrn` goes 1 on the first `clk` edge and stays 1.
- IDLE: `start`=1 is accepted.
  - Load shift register with `P_Data`.
  - `sout` ← `P_Data[DATA_BITS-1]`, `busy` ← 1, bit counter ← 0, go to SHIFT.
- SHIFT: each bit lasts 2·CLK_DIV cycles.
  - `s_clk`=0 for the first CLK_DIV cycles, then 1 for CLK_DIV cycles. `sout` is stable across the rising edge.
  - At the end of each bit, `s_clk` ← 0 and the register shifts left. `sout` takes the next bit.
  - After bit DATA_BITS-1 completes: `s_clk` ← 0, `EN` ← 1, go to LATCH.
- LATCH: `EN` held 1 for CLK_DIV cycles. On exit in the same edge: `EN` ← 0, `done` ← 1 for one cycle, `busy` ← 0, state IDLE.
- `sout` holds the last shifted bit until the next accepted start.
- `start` during SHIFT/LATCH is ignored (not queued). `P_Data` changes after capture have no effect.
- `start`=1 in the cycle `done`=1 is accepted: state is already IDLE. `done` and the new `busy` coexist for that edge's outputs.
- Bit counter width is $clog2(DATA_BITS); phase counter width is $clog2(CLK_DIV)+1. Neither wraps mid-transfer.
- `rstn` asserted mid-transfer aborts immediately to reset values. No latch pulse is issued.

## Timing
- Start accepted at edge k (all times below in `clk` edges from k):
  - `busy`=1 and `sout` = MSB from k.
  - n-th `s_clk` rising edge (n = 0..DATA_BITS-1) at k + 2·CLK_DIV·n + CLK_DIV.
  - `EN` rises at k + 2·CLK_DIV·DATA_BITS and falls CLK_DIV cycles later.
  - `done` is high for the single cycle starting at k + 2·CLK_DIV·DATA_BITS + CLK_DIV; `busy` falls at that edge.
- Total transfer: 2·CLK_DIV·DATA_BITS + CLK_DIV cycles (258 for defaults).
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- `P2S_AUTOREFRESH_EN` defined: an idle counter runs while in IDLE and clears on leaving IDLE.
  - When it reaches REFRESH_CYCLES-1, an internal start fires and re-samples `P_Data`.
  - The first automatic transfer follows REFRESH_CYCLES idle cycles after reset.
  - External `start` still works and has priority; the counter clears on acceptance.
- Undefined: transfers occur only on external `start`. `REFRESH_CYCLES` is unused and no counter is synthesized.

## Test plan
- Reset check: hold `rstn`=0 → `s_clrn`=0 and all other outputs 0. Release → `s_clrn`=1 one edge later; `busy` stays 0 with no start.
- Pattern, defaults: `P_Data`=64'h8000_0000_0000_0001, pulse `start` → required:
  - `sout` 1, then 62 zeros, then 1, sampled on `s_clk` rises.
  - Exactly 64 rises, the first at k+2.
  - `EN` high cycles 256–257; `done` at 258; `busy` low from 258.
- Ignore/capture: start with 64'hA5A5…A5; pulse `start` and change `P_Data` to 0 at cycle 50 → serial stream is still A5A5…A5, and exactly one `done`.
- Back-to-back: hold `start`=1 continuously → successive transfers begin on each `done` cycle, no idle gap. Second `sout` MSB appears at k+258.
- Abort: assert `rstn`=0 at cycle 100 of a transfer → outputs are at reset values immediately, with no `EN` pulse. After release, a new start completes normally.
- Auto-refresh (macro defined, REFRESH_CYCLES=16, no `start`) → first transfer begins after 16 idle cycles post-reset. Subsequent starts come 16 cycles after each `done`, and each picks up an updated `P_Data`.

Source files
------------

// File: rtl/seg_p2s_shifter_if.sv
// rtl/seg_p2s_shifter_if.sv - request/pattern inputs and serial-chain outputs of seg_p2s_shifter
interface seg_p2s_shifter_if #(
   parameter int DATA_BITS = 64
);
   logic                 start;
   logic [DATA_BITS-1:0] P_Data;
   logic                 s_clk;
   logic                 s_clrn;
   logic                 sout;
   logic                 EN;
   logic                 busy;
   logic                 done;

   modport master (
      output start, P_Data,
      input  s_clk, s_clrn, sout, EN, busy, done
   );

   modport slave (
      input  start, P_Data,
      output s_clk, s_clrn, sout, EN, busy, done
   );
endinterface

// File: rtl/seg_p2s_shifter.sv
// rtl/seg_p2s_shifter.sv - MSB-first parallel-to-serial driver for the 7-segment chain; optional P2S_AUTOREFRESH_EN
module seg_p2s_shifter #(
   parameter int DATA_BITS      = 64,
   parameter int CLK_DIV        = 2,
   parameter int REFRESH_CYCLES = 1024
) (
   input logic              clk,
   input logic              rstn,
   seg_p2s_shifter_if.slave bus
);
   localparam int              BC_W    = $clog2(DATA_BITS);
   localparam int              PH_W    = $clog2(CLK_DIV) + 1;
   localparam logic [PH_W-1:0] PH_RISE = PH_W'(CLK_DIV - 1);
   localparam logic [PH_W-1:0] PH_END  = PH_W'(2 * CLK_DIV - 1);
   localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_BITS - 1);

   if (DATA_BITS < 2 || CLK_DIV < 1 || REFRESH_CYCLES < 1) begin : g_param_check
      $error("seg_p2s_shifter: illegal parameter set");
   end

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      LATCH = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic [BC_W-1:0]      bit_cnt_q, bit_cnt_d;
   logic [PH_W-1:0]      phase_q, phase_d;
   logic                 s_clk_q, s_clk_d;
   logic                 s_clrn_q, s_clrn_d;
   logic                 sout_q, sout_d;
   logic                 en_q, en_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 go;
   logic                 load;

`ifdef P2S_AUTOREFRESH_EN
   localparam int IC_W = $clog2(REFRESH_CYCLES + 1);
   logic [IC_W-1:0] idle_q, idle_d;
`endif

   // State and output registers; every output comes straight from a flop
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= IDLE;
         shreg_q   <= '0;
         bit_cnt_q <= '0;
         phase_q   <= '0;
         s_clk_q   <= 1'b0;
         s_clrn_q  <= 1'b0;
         sout_q    <= 1'b0;
         en_q      <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
`ifdef P2S_AUTOREFRESH_EN
         idle_q    <= '0;
`endif
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         bit_cnt_q <= bit_cnt_d;
         phase_q   <= phase_d;
         s_clk_q   <= s_clk_d;
         s_clrn_q  <= s_clrn_d;
         sout_q    <= sout_d;
         en_q      <= en_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
`ifdef P2S_AUTOREFRESH_EN
         idle_q    <= idle_d;
`endif
      end
   end

   // Next-state logic: bit timing in SHIFT, latch pulse in LATCH, and capture on an accepted request
   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
      phase_d   = phase_q;
      s_clk_d   = s_clk_q;
      s_clrn_d  = 1'b1;
      sout_d    = sout_q;
      en_d      = en_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      load      = 1'b0;

`ifdef P2S_AUTOREFRESH_EN
      go = bus.start || (idle_q == IC_W'(REFRESH_CYCLES - 1));
`else
      go = bus.start;
`endif

      case (state_q)
         IDLE: begin
            if (go) load = 1'b1;
         end
         SHIFT: begin
            if (phase_q == PH_RISE) begin
               s_clk_d = 1'b1;
               phase_d = phase_q + PH_W'(1);
            end else if (phase_q == PH_END) begin
               s_clk_d = 1'b0;
               phase_d = '0;
               if (bit_cnt_q == BC_LAST) begin
                  // Last bit stays on sout; the chain is latched next
                  en_d    = 1'b1;
                  state_d = LATCH;
               end else begin
                  shreg_d   = shreg_q << 1;
                  sout_d    = shreg_q[DATA_BITS-2];
                  bit_cnt_d = bit_cnt_q + BC_W'(1);
               end
            end else begin
               phase_d = phase_q + PH_W'(1);
            end
         end
         LATCH: begin
            if (phase_q == PH_RISE) begin
               en_d    = 1'b0;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               phase_d = '0;
               state_d = IDLE;
               // A request seen on the completion edge starts the next transfer with no gap
               if (bus.start) load = 1'b1;
            end else begin
               phase_d = phase_q + PH_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (load) begin
         shreg_d   = bus.P_Data;
         sout_d    = bus.P_Data[DATA_BITS-1];
         busy_d    = 1'b1;
         bit_cnt_d = '0;
         phase_d   = '0;
         s_clk_d   = 1'b0;
         state_d   = SHIFT;
      end
   end

`ifdef P2S_AUTOREFRESH_EN
   // Idle gap counter: runs only while staying in IDLE, cleared whenever a transfer starts
   always_comb begin
      idle_d = '0;
      if (state_q == IDLE && state_d == IDLE) idle_d = idle_q + IC_W'(1);
   end
`endif

   assign bus.s_clk  = s_clk_q;
   assign bus.s_clrn = s_clrn_q;
   assign bus.sout   = sout_q;
   assign bus.EN     = en_q;
   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
endmodule
